// File: rtl/unique_draw_pkg.sv
// Shared definitions for the unique_draw_seq block.
//   state_t     : draw sequencer FSM states (SHUFFLE, HOLD, DONE)
//   clog2_safe  : ceiling log2 that never returns less than 1, so counters
//                 sized from small parameters always have at least one bit
package unique_draw_pkg;

    typedef enum logic [1:0] {
        SHUFFLE = 2'd0,
        HOLD    = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int clog2_safe(input int value);
        if (value <= 1) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/unique_draw_seq_hold_timer.sv
// hold_timer: down-counter that stays busy for exactly HOLD_CYCLES cycles
// after a load pulse.
//   clk    : system clock
//   rst    : synchronous active-high reset (also used for round clear)
//   load   : start a hold period; counter loads HOLD_CYCLES-1
//   busy   : registered, high while the hold period runs
//   expire : high in the last busy cycle (counter at zero)
module hold_timer
    import unique_draw_pkg::*;
#(
    parameter int HOLD_CYCLES = 200000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy,
    output logic expire
);

    localparam int CNT_W = clog2_safe(HOLD_CYCLES);

    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    // Countdown register and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (load) begin
            cnt_r  <= CNT_W'(HOLD_CYCLES - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (cnt_r == {CNT_W{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r  <= cnt_r;
            busy_r <= busy_r;
        end
    end

    assign busy   = busy_r;
    assign expire = busy_r && (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/unique_draw_seq.sv
// unique_draw_seq: no-repeat draw sequencer.
// Shows live random values, latches one on each draw request, freezes it for
// HOLD_CYCLES cycles and keeps a history of DEPTH drawn values so that no
// value repeats within a round. done rises after DEPTH draws.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   r_in     : free-running random value
//   draw     : single-cycle draw request
//   clear    : synchronous round restart (same effect as rst)
//   r_out    : displayed value (registered)
//   r_valid  : r_out holds a value not present in history
//   holding  : hold timer running, r_out frozen
//   draw_cnt : draws committed this round
//   done     : round complete
// Optional build macro UNIQUE_DRAW_EXCLUDE_ZERO_EN: value 0 is treated as a
// duplicate (never shown valid, never committed); DEPTH limited to 2**WIDTH-1.
module unique_draw_seq
    import unique_draw_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 200000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             r_in,
    input  logic                         draw,
    input  logic                         clear,
    output logic [WIDTH-1:0]             r_out,
    output logic                         r_valid,
    output logic                         holding,
    output logic [$clog2(DEPTH+1)-1:0]   draw_cnt,
    output logic                         done
);

    localparam int CNT_W = clog2_safe(DEPTH + 1);

`ifdef UNIQUE_DRAW_EXCLUDE_ZERO_EN
    localparam longint MAX_DEPTH = (64'sd1 <<< WIDTH) - 64'sd1;
`else
    localparam longint MAX_DEPTH = (64'sd1 <<< WIDTH);
`endif

    if (DEPTH < 1 || longint'(DEPTH) > MAX_DEPTH) begin : g_depth_check
        $error("unique_draw_seq: DEPTH out of range");
    end
    if (HOLD_CYCLES < 1) begin : g_hold_check
        $error("unique_draw_seq: HOLD_CYCLES must be >= 1");
    end

    state_t             state_r;
    logic [WIDTH-1:0]   r_out_r;
    logic               r_valid_r;
    logic [CNT_W-1:0]   draw_cnt_r;
    logic               done_r;
    logic [WIDTH-1:0]   history_r   [DEPTH];
    logic [DEPTH-1:0]   hist_valid_r;

    logic [DEPTH-1:0]   match_s;
    logic               dup_s;
    logic               restart_s;
    logic               commit_s;
    logic               timer_busy_s;
    logic               timer_expire_s;

    assign restart_s = rst | clear;
    // A draw only commits from SHUFFLE with a value already checked unique.
    assign commit_s  = (state_r == SHUFFLE) && draw && r_valid_r;

    // Duplicate check of live r_in against every valid history entry.
    always_comb begin
        match_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = hist_valid_r[i] && (history_r[i] == r_in);
        end
`ifdef UNIQUE_DRAW_EXCLUDE_ZERO_EN
        dup_s = (|match_s) || (r_in == {WIDTH{1'b0}});
`else
        dup_s = |match_s;
`endif
    end

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (restart_s),
        .load   (commit_s),
        .busy   (timer_busy_s),
        .expire (timer_expire_s)
    );

    // Sequencer FSM, history storage and registered outputs.
    always_ff @(posedge clk) begin
        if (restart_s) begin
            state_r      <= SHUFFLE;
            r_out_r      <= {WIDTH{1'b0}};
            r_valid_r    <= 1'b0;
            draw_cnt_r   <= {CNT_W{1'b0}};
            done_r       <= 1'b0;
            hist_valid_r <= {DEPTH{1'b0}};
        end else begin
            case (state_r)
                SHUFFLE: begin
                    if (commit_s) begin
                        // r_out was checked against the unchanged history,
                        // so this entry can never duplicate an earlier one.
                        for (int i = 0; i < DEPTH; i++) begin
                            if (draw_cnt_r == CNT_W'(i)) begin
                                history_r[i]    <= r_out_r;
                                hist_valid_r[i] <= 1'b1;
                            end else begin
                                history_r[i]    <= history_r[i];
                                hist_valid_r[i] <= hist_valid_r[i];
                            end
                        end
                        draw_cnt_r <= draw_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r    <= HOLD;
                    end else if (!dup_s) begin
                        r_out_r   <= r_in;
                        r_valid_r <= 1'b1;
                    end else begin
                        r_out_r   <= r_out_r;
                        r_valid_r <= r_valid_r;
                    end
                end
                HOLD: begin
                    if (timer_expire_s) begin
                        // Force a fresh unique sample before the next draw.
                        r_valid_r <= 1'b0;
                        if (draw_cnt_r == CNT_W'(DEPTH)) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= SHUFFLE;
                        end
                    end else begin
                        state_r <= HOLD;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= SHUFFLE;
                end
            endcase
        end
    end

    assign r_out    = r_out_r;
    assign r_valid  = r_valid_r;
    assign holding  = timer_busy_s;
    assign draw_cnt = draw_cnt_r;
    assign done     = done_r;

endmodule

// File: tb/tb_unique_draw_seq.sv
// Self-checking bench for unique_draw_seq (WIDTH=4, DEPTH=3, HOLD_CYCLES=5).
// Each stimulus cycle updates a behavioural model and pushes the expected
// outputs to a scoreboard queue; a negedge monitor pops and compares them.
// Scenario tasks add their own directed checks.
module tb_unique_draw_seq;

    localparam int W    = 4;
    localparam int D    = 3;
    localparam int HOLD = 5;

    typedef struct {
        logic [W-1:0] out;
        logic         valid;
        logic         holding;
        logic [1:0]   cnt;
        logic         done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] r_in;
    logic         draw;
    logic         clear;
    logic [W-1:0] r_out;
    logic         r_valid;
    logic         holding;
    logic [1:0]   draw_cnt;
    logic         done;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];
    exp_t mon_e;

    // model state
    int           m_state;
    logic [W-1:0] m_out;
    logic         m_valid;
    int           m_cnt;
    logic         m_done;
    int           m_hold;
    logic [W-1:0] m_hist[$];

    unique_draw_seq #(
        .WIDTH       (W),
        .DEPTH       (D),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r_in     (r_in),
        .draw     (draw),
        .clear    (clear),
        .r_out    (r_out),
        .r_valid  (r_valid),
        .holding  (holding),
        .draw_cnt (draw_cnt),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic is_dup(input logic [W-1:0] v);
        logic d;
        d = 1'b0;
        foreach (m_hist[i]) if (m_hist[i] == v) d = 1'b1;
`ifdef UNIQUE_DRAW_EXCLUDE_ZERO_EN
        if (v == 4'd0) d = 1'b1;
`endif
        return d;
    endfunction

    task automatic model_cycle(input logic [W-1:0] rin, input logic drw, input logic rs);
        if (rs) begin
            m_state = 0; m_out = 4'd0; m_valid = 1'b0; m_cnt = 0;
            m_done = 1'b0; m_hold = 0; m_hist.delete();
        end else begin
            case (m_state)
                0: begin
                    if (drw && m_valid) begin
                        m_hist.push_back(m_out);
                        m_cnt++;
                        m_hold  = HOLD;
                        m_state = 1;
                    end else if (!is_dup(rin)) begin
                        m_out   = rin;
                        m_valid = 1'b1;
                    end
                end
                1: begin
                    m_hold--;
                    if (m_hold == 0) begin
                        m_valid = 1'b0;
                        if (m_cnt == D) begin
                            m_state = 2;
                            m_done  = 1'b1;
                        end else begin
                            m_state = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of stimulus, predict its outcome, wait past the edge.
    task automatic step(input logic [W-1:0] rin, input logic drw,
                        input logic clr, input logic rs);
        exp_t e;
        r_in = rin; draw = drw; clear = clr; rst = rs;
        model_cycle(rin, drw, clr | rs);
        e.out = m_out; e.valid = m_valid; e.holding = (m_state == 1);
        e.cnt = 2'(m_cnt); e.done = m_done;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: compare DUT outputs with predictions.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            checks += 5;
            if (r_out !== mon_e.out) begin
                errors++; $display("FAIL sb_r_out: got %0d expected %0d at %0t", r_out, mon_e.out, $time);
            end
            if (r_valid !== mon_e.valid) begin
                errors++; $display("FAIL sb_r_valid: got %0b expected %0b at %0t", r_valid, mon_e.valid, $time);
            end
            if (holding !== mon_e.holding) begin
                errors++; $display("FAIL sb_holding: got %0b expected %0b at %0t", holding, mon_e.holding, $time);
            end
            if (draw_cnt !== mon_e.cnt) begin
                errors++; $display("FAIL sb_draw_cnt: got %0d expected %0d at %0t", draw_cnt, mon_e.cnt, $time);
            end
            if (done !== mon_e.done) begin
                errors++; $display("FAIL sb_done: got %0b expected %0b at %0t", done, mon_e.done, $time);
            end
        end
    end

    task automatic wait_hold_end();
        for (int k = 0; k < 20 && holding; k++) step(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
        checks++;
        if (holding !== 1'b0) begin
            errors++; $display("FAIL hold_timeout: holding got %0b expected 0", holding);
        end
    endtask

    task automatic test_reset();
        step(4'd7, 1'b0, 1'b0, 1'b1);
        step(4'd7, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({r_out, r_valid, holding, draw_cnt, done} !== 9'd0) begin
            errors++; $display("FAIL reset_state: got %h expected 0", {r_out, r_valid, holding, draw_cnt, done});
        end
    endtask

    task automatic test_first_draw();
        int hcnt;
        step(4'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_out !== 4'd5 || r_valid !== 1'b1) begin
            errors++; $display("FAIL first_show: r_out %0d r_valid %0b expected 5 1", r_out, r_valid);
        end
        step(4'd6, 1'b1, 1'b0, 1'b0);
        checks++;
        if (holding !== 1'b1 || draw_cnt !== 2'd1) begin
            errors++; $display("FAIL first_commit: holding %0b draw_cnt %0d expected 1 1", holding, draw_cnt);
        end
        hcnt = 1;
        for (int k = 0; k < 20 && holding; k++) begin
            step(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
            if (holding) hcnt++;
            checks++;
            if (r_out !== 4'd5) begin
                errors++; $display("FAIL hold_frozen: r_out %0d expected 5", r_out);
            end
        end
        checks++;
        if (hcnt !== HOLD) begin
            errors++; $display("FAIL hold_length: got %0d cycles expected %0d", hcnt, HOLD);
        end
    endtask

    task automatic test_duplicate();
        for (int k = 0; k < 10; k++) step(4'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_valid !== 1'b0) begin
            errors++; $display("FAIL dup_rejected: r_valid %0b expected 0", r_valid);
        end
        step(4'd5, 1'b1, 1'b0, 1'b0);
        checks++;
        if (draw_cnt !== 2'd1 || holding !== 1'b0) begin
            errors++; $display("FAIL draw_invalid_ignored: draw_cnt %0d holding %0b expected 1 0", draw_cnt, holding);
        end
        step(4'd9, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_out !== 4'd9 || r_valid !== 1'b1) begin
            errors++; $display("FAIL new_unique: r_out %0d r_valid %0b expected 9 1", r_out, r_valid);
        end
    endtask

    task automatic test_done();
        step(4'd3, 1'b1, 1'b0, 1'b0);
        step(4'd4, 1'b0, 1'b0, 1'b0);
        step(4'd8, 1'b1, 1'b0, 1'b0);
        checks++;
        if (draw_cnt !== 2'd2) begin
            errors++; $display("FAIL draw_in_hold_ignored: draw_cnt %0d expected 2", draw_cnt);
        end
        wait_hold_end();
        step(4'd2, 1'b0, 1'b0, 1'b0);
        step(4'd2, 1'b1, 1'b0, 1'b0);
        wait_hold_end();
        checks++;
        if (done !== 1'b1 || draw_cnt !== 2'd3) begin
            errors++; $display("FAIL round_done: done %0b draw_cnt %0d expected 1 3", done, draw_cnt);
        end
        step(4'd7, 1'b1, 1'b0, 1'b0);
        step(4'd7, 1'b0, 1'b0, 1'b0);
        checks++;
        if (r_out !== 4'd2 || draw_cnt !== 2'd3 || done !== 1'b1) begin
            errors++; $display("FAIL done_frozen: r_out %0d draw_cnt %0d done %0b expected 2 3 1", r_out, draw_cnt, done);
        end
    endtask

    task automatic test_clear();
        step(4'd0, 1'b0, 1'b1, 1'b0);
        step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd5, 1'b1, 1'b0, 1'b0);
        step(4'd1, 1'b0, 1'b0, 1'b0);
        step(4'd6, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({r_out, r_valid, holding, draw_cnt, done} !== 9'd0) begin
            errors++; $display("FAIL clear_mid_hold: got %h expected 0", {r_out, r_valid, holding, draw_cnt, done});
        end
        step(4'd5, 1'b0, 1'b0, 1'b0);
        step(4'd3, 1'b1, 1'b0, 1'b0);
        checks++;
        if (draw_cnt !== 2'd1 || holding !== 1'b1) begin
            errors++; $display("FAIL redraw_after_clear: draw_cnt %0d holding %0b expected 1 1", draw_cnt, holding);
        end
    endtask

    task automatic test_zero();
        step(4'd0, 1'b0, 1'b1, 1'b0);
        step(4'd0, 1'b0, 1'b0, 1'b0);
        step(4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
`ifdef UNIQUE_DRAW_EXCLUDE_ZERO_EN
        if (r_valid !== 1'b0 || draw_cnt !== 2'd0) begin
            errors++; $display("FAIL zero_excluded: r_valid %0b draw_cnt %0d expected 0 0", r_valid, draw_cnt);
        end
`else
        if (draw_cnt !== 2'd1 || r_out !== 4'd0) begin
            errors++; $display("FAIL zero_drawable: draw_cnt %0d r_out %0d expected 1 0", draw_cnt, r_out);
        end
`endif
    endtask

    task automatic test_random();
        step(4'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 400; k++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 80) == 0), 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; r_in = 4'd0; draw = 1'b0; clear = 1'b0;
        test_reset();
        test_first_draw();
        test_duplicate();
        test_done();
        test_clear();
        test_zero();
        test_random();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
